// File: rtl/ram_bank_controller_if.sv
// Processor port-mapped I/O bus plus the shared RAM-bank control lines of ram_bank_controller.
// master = processor / bench side, slave = controller side.
interface ram_bank_controller_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            port_id;
  logic [7:0]            out_port;
  logic                  write_strobe;
  logic                  read_strobe;
  logic                  ram_sel;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_wdata;
  logic                  ram_we_1;
  logic                  ram_we_2;
  logic [7:0]            status;

  modport master (
    output port_id, out_port, write_strobe, read_strobe,
    input  ram_sel, ram_addr, ram_wdata, ram_we_1, ram_we_2, status
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe,
    output ram_sel, ram_addr, ram_wdata, ram_we_1, ram_we_2, status
  );
endinterface

// File: rtl/ram_bank_controller.sv
// Port-mapped front end for two async-read RAM banks: address pointer, bank select,
// single-cycle DATA write pulses and a block-fill engine that locks out the processor while busy.
module ram_bank_controller #(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] BASE_PORT  = 8'h10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_bank_controller_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;

  localparam logic [7:0]            PORT_ADDR = BASE_PORT;
  localparam logic [7:0]            PORT_BANK = BASE_PORT + 8'd1;
  localparam logic [7:0]            PORT_DATA = BASE_PORT + 8'd2;
  localparam logic [7:0]            PORT_FILL = BASE_PORT + 8'd3;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pointer_q, pointer_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] fill_ptr_q, fill_ptr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  sel_q, sel_d;
  logic                  wrap_q, wrap_d;
  logic                  wr_pend_q, wr_pend_d;

  logic idle;
  logic wr_addr, wr_bank, wr_data, wr_fill, rd_data;
  logic ptr_inc;
  logic fill_last;

  // Every strobe is dropped while the fill engine owns the banks.
  assign idle    = (state_q == IDLE);
  assign wr_addr = idle && bus.write_strobe && (bus.port_id == PORT_ADDR);
  assign wr_bank = idle && bus.write_strobe && (bus.port_id == PORT_BANK);
  assign wr_data = idle && bus.write_strobe && (bus.port_id == PORT_DATA);
  assign wr_fill = idle && bus.write_strobe && (bus.port_id == PORT_FILL);
  // A read coinciding with any write is not counted as an access.
  assign rd_data = idle && bus.read_strobe && !bus.write_strobe && (bus.port_id == PORT_DATA);

  assign ptr_inc   = wr_data || rd_data;
  assign fill_last = (state_q == FILL) && (fill_ptr_q == ADDR_MAX);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_fill)   state_d = FILL;
      FILL:    if (fill_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the single bank write enable, shared address and write data
  always_comb begin
    bus.ram_we_1 = 1'b0;
    bus.ram_we_2 = 1'b0;
    bus.ram_addr = pointer_q;
    if (wr_pend_q) begin
      bus.ram_addr = waddr_q;
      bus.ram_we_1 = !sel_q;
      bus.ram_we_2 = sel_q;
    end else if (state_q == FILL) begin
      bus.ram_addr = fill_ptr_q;
      bus.ram_we_1 = !sel_q;
      bus.ram_we_2 = sel_q;
    end
  end

  assign bus.ram_wdata = wdata_q;
  assign bus.ram_sel   = sel_q;
  assign bus.status    = {(state_q == FILL), wrap_q, 5'b0, sel_q};

  // Register-map datapath; the fill byte shares the write-data register.
  always_comb begin
    pointer_d  = pointer_q;
    waddr_d    = waddr_q;
    fill_ptr_d = fill_ptr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    wrap_d     = wrap_q;
    wr_pend_d  = wr_data;

    if (wr_addr) begin
      pointer_d = bus.out_port[ADDR_WIDTH-1:0];
      wrap_d    = 1'b0;
    end
    if (wr_bank) begin
      sel_d = bus.out_port[0];
    end
    if (wr_data) begin
      waddr_d = pointer_q;
      wdata_d = bus.out_port;
    end
    if (wr_fill) begin
      wdata_d    = bus.out_port;
      fill_ptr_d = pointer_q;
    end
    if (ptr_inc) begin
      pointer_d = pointer_q + 1'b1;
      if (pointer_q == ADDR_MAX) begin
        wrap_d = 1'b1;
      end
    end
    if (state_q == FILL) begin
      if (fill_last) begin
        pointer_d = '0;
        wrap_d    = 1'b1;
      end else begin
        fill_ptr_d = fill_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pointer_q  <= '0;
      waddr_q    <= '0;
      fill_ptr_q <= '0;
      wdata_q    <= '0;
      sel_q      <= 1'b0;
      wrap_q     <= 1'b0;
      wr_pend_q  <= 1'b0;
    end else begin
      pointer_q  <= pointer_d;
      waddr_q    <= waddr_d;
      fill_ptr_q <= fill_ptr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      wrap_q     <= wrap_d;
      wr_pend_q  <= wr_pend_d;
    end
  end

endmodule

// File: tb/tb_ram_bank_controller.sv
// Directed bench: stimulus pushes expected bank writes/reads into queues, a negedge monitor pops and compares.
module tb_ram_bank_controller;

  localparam logic [7:0] P_ADDR = 8'h10;
  localparam logic [7:0] P_BANK = 8'h11;
  localparam logic [7:0] P_DATA = 8'h12;
  localparam logic [7:0] P_FILL = 8'h13;

  typedef struct packed {
    logic       we1;
    logic       we2;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   busy_cycles;
  wr_t        wr_q[$];
  logic [7:0] rd_q[$];

  ram_bank_controller_if #(.ADDR_WIDTH(8)) bus ();

  ram_bank_controller #(.ADDR_WIDTH(8), .BASE_PORT(8'h10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in for ram_out_selector: the bank model returns addr+1, sampled on read strobes.
  always @(negedge clk) begin
    wr_t        e;
    logic [7:0] ea;
    if (rst_n) begin
      if (bus.status[7]) busy_cycles++;
      if (bus.ram_we_1 || bus.ram_we_2) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_we", {bus.ram_we_1, bus.ram_we_2, bus.ram_addr, bus.ram_wdata}, 32'h0);
        end else begin
          e = wr_q.pop_front();
          chk("bank_write", {bus.ram_we_1, bus.ram_we_2, bus.ram_addr, bus.ram_wdata}, e);
        end
      end
      if (bus.read_strobe && !bus.write_strobe && bus.port_id == P_DATA) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_read", {8'h0, bus.ram_addr}, 32'hFFFF);
        end else begin
          ea = rd_q.pop_front();
          chk("read_addr_data", {bus.ram_addr, bus.ram_addr + 8'd1}, {ea, ea + 8'd1});
        end
      end
    end
  end

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    @(posedge clk); #1;
    bus.port_id      = port;
    bus.out_port     = data;
    bus.write_strobe = 1'b1;
    @(posedge clk); #1;
    bus.write_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic sel, input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.we1  = !sel;
    e.we2  = sel;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; busy_cycles = 0;
    rst_n = 1'b0;
    bus.port_id = 8'h00; bus.out_port = 8'h00;
    bus.write_strobe = 1'b0; bus.read_strobe = 1'b0;
    idle(3);
    chk("reset_status", bus.status, 8'h00);
    chk("reset_addr", bus.ram_addr, 8'h00);
    chk("reset_we", {bus.ram_we_1, bus.ram_we_2}, 2'b00);
    chk("reset_wdata", bus.ram_wdata, 8'h00);
    rst_n = 1'b1;
    idle(1);

    // Two DATA writes into bank 1
    io_write(P_ADDR, 8'h05);
    io_write(P_BANK, 8'h00);
    push_wr(1'b0, 8'h05, 8'hAA); io_write(P_DATA, 8'hAA);
    push_wr(1'b0, 8'h06, 8'hBB); io_write(P_DATA, 8'hBB);
    idle(1);
    chk("ptr_after_writes", bus.ram_addr, 8'h07);

    // Pointer wrap on bank 2
    io_write(P_BANK, 8'h01);
    io_write(P_ADDR, 8'hFF);
    chk("status_before_wrap", bus.status, 8'h01);
    push_wr(1'b1, 8'hFF, 8'h11); io_write(P_DATA, 8'h11);
    chk("status_wrap_first", bus.status, 8'h41);
    push_wr(1'b1, 8'h00, 8'h22); io_write(P_DATA, 8'h22);
    idle(1);
    chk("status_wrap_sticky", bus.status, 8'h41);
    chk("ptr_after_wrap", bus.ram_addr, 8'h01);

    // Three back-to-back DATA reads
    io_write(P_ADDR, 8'h10);
    chk("wrap_cleared", bus.status, 8'h01);
    rd_q.push_back(8'h10); rd_q.push_back(8'h11); rd_q.push_back(8'h12);
    @(posedge clk); #1;
    bus.port_id = P_DATA; bus.read_strobe = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.read_strobe = 1'b0;
    idle(1);
    chk("ptr_after_reads", bus.ram_addr, 8'h13);

    // Fill 0xFC..0xFF, DATA write mid-fill must be ignored
    io_write(P_ADDR, 8'hFC);
    for (int a = 8'hFC; a <= 8'hFF; a++) push_wr(1'b1, 8'(a), 8'h5A);
    busy_cycles = 0;
    io_write(P_FILL, 8'h5A);
    io_write(P_DATA, 8'h77);
    for (int i = 0; i < 50 && bus.status[7]; i++) idle(1);
    chk("fill_done", bus.status[7], 1'b0);
    chk("fill_busy_cycles", busy_cycles, 4);
    chk("fill_end_status", bus.status, 8'h41);
    chk("fill_end_ptr", bus.ram_addr, 8'h00);

    // Reset in the middle of a fill from 0x00
    io_write(P_ADDR, 8'h00);
    for (int a = 0; a < 9; a++) push_wr(1'b1, 8'(a), 8'h33);
    io_write(P_FILL, 8'h33);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_fill_we", {bus.ram_we_1, bus.ram_we_2}, 2'b00);
    chk("rst_mid_fill_status", bus.status, 8'h00);
    chk("rst_mid_fill_addr", bus.ram_addr, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    push_wr(1'b0, 8'h00, 8'h9C); io_write(P_DATA, 8'h9C);
    idle(1);
    chk("post_rst_ptr", bus.ram_addr, 8'h01);

    // Unmapped port, then write and read together on DATA
    io_write(8'h14, 8'hEE);
    idle(1);
    chk("unmapped_status", bus.status, 8'h00);
    chk("unmapped_ptr", bus.ram_addr, 8'h01);
    push_wr(1'b0, 8'h01, 8'h4D);
    @(posedge clk); #1;
    bus.port_id = P_DATA; bus.out_port = 8'h4D;
    bus.write_strobe = 1'b1; bus.read_strobe = 1'b1;
    @(posedge clk); #1;
    bus.write_strobe = 1'b0; bus.read_strobe = 1'b0;
    idle(2);
    chk("wr_rd_ptr", bus.ram_addr, 8'h02);

    idle(3);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_bank_controller.md
Name: ram_bank_controller

Overview:
- Port-mapped front end between the processor I/O bus (port_id, out_port, write_strobe, read_strobe) and two asynchronous-read 8-bit RAM banks.
- Owns the address pointer, bank select and write enables for both banks, and runs a hardware block-fill engine.
- Sits directly upstream of ram_out_selector. It drives ram_sel, and bank 1 and bank 2 read data return through ram_out_selector as data_in_1 and data_in_2.

Parameters:
- ADDR_WIDTH, 8, bank address width (depth 2^ADDR_WIDTH per bank).
- BASE_PORT, 8'h10, port_id of the first control register; registers occupy BASE_PORT..BASE_PORT+3.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- port_id  input  8  processor I/O address.
- out_port  input  8  processor write data.
- write_strobe  input  1  one-cycle write qualifier.
- read_strobe  input  1  one-cycle read qualifier.
- ram_sel  output  1  registered bank select, 0 = bank 1, 1 = bank 2; feeds ram_out_selector.
- ram_addr  output  ADDR_WIDTH  shared bank address.
- ram_wdata  output  8  shared bank write data.
- ram_we_1  output  1  bank 1 write enable.
- ram_we_2  output  1  bank 2 write enable.
- status  output  8  {busy, wrap, 5'b0, ram_sel}.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: pointer=0, ram_sel=0, wrap=0, busy=0, state=IDLE, ram_we_1=ram_we_2=0, ram_wdata=0, wr_pend=0. ram_addr therefore reads 0.
- Register map, decoded on an exact port_id match:
  - BASE+0 ADDR (write): pointer<=out_port[ADDR_WIDTH-1:0]; wrap<=0.
  - BASE+1 BANK (write): ram_sel<=out_port[0].
  - BASE+2 DATA, write: latch waddr<=pointer and ram_wdata<=out_port. Next cycle, pulse ram_we_(ram_sel+1) for exactly 1 cycle. Pointer post-increments at the strobe edge.
  - BASE+2 DATA, read: RAM output is combinational at ram_addr=pointer and ram_out_selector samples it at the strobe edge. Pointer post-increments at that same edge, so back-to-back reads stream consecutive addresses.
  - BASE+3 FILL (write): fill_val<=out_port, fill_ptr<=pointer, state<=FILL, busy<=1.
- ram_addr mux:
  - waddr while a DATA write pulse is active.
  - fill_ptr in FILL.
  - pointer otherwise.
- Pointer increment wraps from 2^ADDR_WIDTH-1 to 0 and sets wrap=1. wrap is sticky until an ADDR write.
- FSM IDLE -> FILL -> IDLE:
  - FILL: each cycle asserts the selected bank's we with ram_wdata=fill_val at fill_ptr, then increments fill_ptr.
  - On the cycle writing address 2^ADDR_WIDTH-1: state<=IDLE, busy<=0, pointer<=0, wrap<=1.
  - Fill length = 2^ADDR_WIDTH - start address. A start at max is 1 write.
- While busy, all strobes are ignored: no register change, no pointer increment, no we. The read still passes RAM data through ram_out_selector.
- Only one we is ever high, and never both.
- Simultaneous write_strobe and read_strobe: the write is serviced and the read does not increment the pointer.
- Non-matching port_id: no effect.
- ram_sel changes only via a BANK write, never during FILL.
- Reset mid-FILL: immediately returns to reset values, we drops asynchronously, and fill is abandoned.
- Latency:
  - DATA write to RAM: 1 cycle.
  - FILL start to first we: 1 cycle.
  - busy deasserts the cycle after the last fill write.

Test Plan:
- Reset, then ADDR=0x05, BANK=0, DATA write 0xAA, DATA write 0xBB -> ram_we_1 pulses at addr 0x05/0xAA then 0x06/0xBB, ram_we_2 stays 0, pointer ends at 0x07.
- BANK=1, ADDR=0xFF, DATA write 0x11, then DATA write 0x22 -> ram_we_2 at 0xFF then 0x00. status=8'h41 (wrap=1, sel=1), with wrap set on the first write.
- ADDR=0x10, three DATA reads with the bank model returning addr+1 -> ram_addr 0x10,0x11,0x12 on the strobe edges; ram_out_selector outputs 0x11,0x12,0x13; pointer=0x13.
- ADDR=0xFC, FILL 0x5A -> busy high for 4 cycles, we at 0xFC..0xFF with 0x5A. Then busy=0, pointer=0, wrap=1. A DATA write issued mid-fill produces no extra we.
- Fill from 0x00 with rst_n pulsed low at cycle 10 -> all we outputs drop immediately, status=0, ram_addr=0; a fresh DATA write after reset works normally.
- write_strobe with port_id=BASE+4, and write plus read together on DATA -> no effect for the first; exactly one write and one increment for the second.
